// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states and forwarding-mux encodings for the pipeline hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MWAIT, LUSTALL, FLUSH} state_e;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: EX operand forwarding select for one source register, MEM result has priority over WB
module fwd_sel import hazard_pkg::*; #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_dst,
  input  logic          wb_regwrite,
  input  logic [AW-1:0] wb_dst,
  output logic [1:0]    fwd
);
  assign fwd = (mem_regwrite && mem_dst != '0 && mem_dst == src) ? FWD_MEM :
               (wb_regwrite && wb_dst != '0 && wb_dst == src)    ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: load-use stall, branch flush, memory-wait freeze and forwarding control
// for the 5-stage pipeline, with saturating stall/flush counters and a sticky timeout flag.
module hazard_ctrl_p import hazard_pkg::*; #(
  parameter int REG_AW       = 5,
  parameter int LU_BUBBLES   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_branch_taken,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_stall,
  output logic              exmem_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              mem_err
);
  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic               lu_hit, mw_hit, timeout, freeze, pc_s, ifid_f, idex_f, br;

  fwd_sel #(.AW(REG_AW)) u_fwd_a (.src(ex_rs), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .fwd(fwd_a));
  fwd_sel #(.AW(REG_AW)) u_fwd_b (.src(ex_rt), .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .fwd(fwd_b));

  always_comb begin
    lu_hit = ex_memread && ex_regwrite && ex_dst != '0 &&
             ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
    mw_hit = mem_req & ~mem_ready;
    timeout = state_q == MWAIT && wait_q == 8'(MEM_TIMEOUT);
    freeze = mw_hit & ~timeout;
    state_d = state_q;
    cnt_d = cnt_q;
    wait_d = wait_q;
    pc_s = 1'b0;
    ifid_f = 1'b0;
    idex_f = 1'b0;
    br = 1'b0;
    // A released MWAIT falls through to the RUN decisions so a frozen branch/load-use is seen now
    if (freeze) begin
      state_d = MWAIT;
      wait_d = state_q == MWAIT ? wait_q + 8'd1 : 8'd1;
      pc_s = 1'b1;
    end else if (state_q == LUSTALL) begin
      pc_s = 1'b1;
      idex_f = 1'b1;
      cnt_d = cnt_q - 3'd1;
      state_d = cnt_q == 3'd1 ? RUN : LUSTALL;
    end else if (state_q == FLUSH) begin
      ifid_f = 1'b1;
      cnt_d = cnt_q - 3'd1;
      state_d = cnt_q == 3'd1 ? RUN : FLUSH;
    end else if (ex_branch_taken) begin
      ifid_f = 1'b1;
      idex_f = 1'b1;
      br = 1'b1;
      cnt_d = 3'(FLUSH_CYCLES - 1);
      state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
    end else if (lu_hit) begin
      pc_s = 1'b1;
      idex_f = 1'b1;
      cnt_d = 3'(LU_BUBBLES - 1);
      state_d = LU_BUBBLES > 1 ? LUSTALL : RUN;
    end else begin
      state_d = RUN;
    end
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_s & ~&stall_cnt_q);
    flush_cnt_d = flush_cnt_q + CNT_W'(br & ~&flush_cnt_q);
    mem_err_d = mem_err_q | (timeout & mw_hit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      wait_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign pc_stall     = reset & pc_s;
  assign ifid_stall   = reset & pc_s;
  assign idex_stall   = reset & freeze;
  assign exmem_stall  = reset & freeze;
  assign memwb_bubble = reset & freeze;
  assign ifid_flush   = reset & ifid_f;
  assign idex_flush   = reset & idex_f;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign mem_err      = mem_err_q;
endmodule
